// File: rtl/demo_seq_pkg.sv
// Shared types and constants for the demo timeline sequencer.
package demo_seq_pkg;

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_PAUSE    = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_FADE_IN  = 2'd3
    } seq_state_t;

    localparam logic [1:0] OP_PLAY  = 2'd0;
    localparam logic [1:0] OP_PAUSE = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_JUMP  = 2'd3;

    localparam int FADE_MAX = 3;
    localparam int TIMER_W  = 13;

endpackage

// File: rtl/demo_timeline_counter.sv
// 13-bit demo timer {frame_counter, frac} with part reload and part/beat pulses.
module demo_timeline_counter
    import demo_seq_pkg::*;
#(
    parameter int PART_BITS       = 3,
    parameter int PART_FRAME_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_en,
    input  logic                 load_en,
    input  logic [PART_BITS-1:0] load_part,
    output logic [TIMER_W-1:0]   timer,
    output logic                 part_start,
    output logic                 beat
);

    // Part field position inside the timer (frac occupies bit 0).
    localparam int PLO = PART_FRAME_BITS + 1;
    localparam int PHI = PLO + PART_BITS - 1;

    logic [TIMER_W-1:0] timer_inc;
    assign timer_inc = timer + TIMER_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer      <= '0;
            part_start <= 1'b0;
            beat       <= 1'b0;
        end else begin
            part_start <= 1'b0;
            beat       <= 1'b0;
            if (load_en) begin
                // Upper frame_counter bits survive a part reload.
                timer      <= {timer[TIMER_W-1:PHI+1], load_part, {PLO{1'b0}}};
                part_start <= 1'b1;
            end else if (inc_en) begin
                timer      <= timer_inc;
                part_start <= (timer_inc[PHI:PLO] != timer[PHI:PLO]);
                beat       <= (timer_inc[4:0] == 5'd0);
            end
        end
    end

endmodule

// File: rtl/demo_sequencer.sv
// Demo timeline controller: play/pause/step/jump commands with a fade around part jumps.
//  state       | meaning
//  ST_PLAY     | timer advances on frame_tick, commands accepted
//  ST_PAUSE    | timer holds, commands accepted
//  ST_FADE_OUT | dimming toward black, target loaded on the tick that finds level 0
//  ST_FADE_IN  | brightening, returns to resume_mode on the tick that finds full level
module demo_sequencer
    import demo_seq_pkg::*;
#(
    parameter int FADE_STEPS      = 4,
    parameter int PART_BITS       = 3,
    parameter int PART_FRAME_BITS = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_tick,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [PART_BITS-1:0]             cmd_part,
    output logic [TIMER_W-1:0]               timer,
    output logic [PART_BITS-1:0]             part,
    output logic [PART_FRAME_BITS-1:0]       frame,
    output logic [$clog2(FADE_STEPS)-1:0]    fade_level,
    output logic                             part_start,
    output logic                             beat,
    output logic                             paused
);

    localparam int FW = $clog2(FADE_STEPS);
    localparam logic [FW-1:0] FADE_TOP = FW'(FADE_STEPS - 1);
    localparam int PLO = PART_FRAME_BITS + 1;

    seq_state_t           state;
    seq_state_t           resume_mode;
    logic [PART_BITS-1:0] target;
    logic                 accept;
    logic                 inc_en;
    logic                 load_en;

    assign accept  = cmd_valid && cmd_ready;
    assign inc_en  = frame_tick && (state == ST_PLAY);
    assign load_en = frame_tick && (state == ST_FADE_OUT) && (fade_level == '0);

    assign part  = timer[PLO+PART_BITS-1:PLO];
    assign frame = timer[PART_FRAME_BITS:1];

    demo_timeline_counter #(
        .PART_BITS       (PART_BITS),
        .PART_FRAME_BITS (PART_FRAME_BITS)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .inc_en     (inc_en),
        .load_en    (load_en),
        .load_part  (target),
        .timer      (timer),
        .part_start (part_start),
        .beat       (beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_PLAY;
            resume_mode <= ST_PLAY;
            target      <= '0;
            fade_level  <= FADE_TOP;
            cmd_ready   <= 1'b1;
            paused      <= 1'b0;
        end else begin
            case (state)
                ST_PLAY, ST_PAUSE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_PLAY: begin
                                state  <= ST_PLAY;
                                paused <= 1'b0;
                            end
                            OP_PAUSE: begin
                                state  <= ST_PAUSE;
                                paused <= 1'b1;
                            end
                            default: begin
                                // STEP and JUMP share the fade path; a jump to the
                                // current part still fades and restarts it.
                                target      <= (cmd_op == OP_STEP) ? part + 1'b1 : cmd_part;
                                resume_mode <= state;
                                state       <= ST_FADE_OUT;
                                cmd_ready   <= 1'b0;
                                paused      <= (state == ST_PAUSE);
                            end
                        endcase
                    end
                end
                ST_FADE_OUT: begin
                    if (frame_tick) begin
                        if (fade_level == '0)
                            state <= ST_FADE_IN;
                        else
                            fade_level <= fade_level - 1'b1;
                    end
                end
                default: begin
                    if (frame_tick) begin
                        if (fade_level == FADE_TOP) begin
                            state     <= resume_mode;
                            cmd_ready <= 1'b1;
                            paused    <= (resume_mode == ST_PAUSE);
                        end else begin
                            fade_level <= fade_level + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demo_sequencer.sv
// Self-checking bench for demo_sequencer: tick-counting reference model plus directed literals.
module tb_demo_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [2:0]  cmd_part = 3'd0;
    logic [12:0] timer;
    logic [2:0]  part;
    logic [6:0]  frame;
    logic [1:0]  fade_level;
    logic        part_start;
    logic        beat;
    logic        paused;

    int total = 0;
    int bad = 0;
    int ps_cnt = 0;
    int beat_cnt = 0;

    demo_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_part   (cmd_part),
        .timer      (timer),
        .part       (part),
        .frame      (frame),
        .fade_level (fade_level),
        .part_start (part_start),
        .beat       (beat),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    // Reference model: plain timer value plus "ticks elapsed since a jump" (-1 = no fade).
    int m_timer = 0;
    int m_fade_ticks = -1;
    int m_target = 0;
    bit m_running = 1'b1;
    bit m_resume_paused = 1'b0;
    bit m_ps = 1'b0;
    bit m_beat = 1'b0;

    always @(posedge clk) begin
        int old_part;
        m_ps = 1'b0;
        m_beat = 1'b0;
        if (reset) begin
            m_timer = 0;
            m_fade_ticks = -1;
            m_target = 0;
            m_running = 1'b1;
            m_resume_paused = 1'b0;
        end else if (m_fade_ticks < 0) begin
            old_part = (m_timer / 256) % 8;
            if (frame_tick && m_running) begin
                m_timer = (m_timer + 1) % 8192;
                m_ps = ((m_timer / 256) % 8) != old_part;
                m_beat = (m_timer % 32) == 0;
            end
            if (cmd_valid) begin
                case (cmd_op)
                    2'd0: m_running = 1'b1;
                    2'd1: m_running = 1'b0;
                    default: begin
                        m_target = (cmd_op == 2'd2) ? (old_part + 1) % 8 : int'(cmd_part);
                        m_resume_paused = !m_running;
                        m_fade_ticks = 0;
                    end
                endcase
            end
        end else if (frame_tick) begin
            m_fade_ticks++;
            if (m_fade_ticks == 4) begin
                m_timer = (m_timer / 2048) * 2048 + m_target * 256;
                m_ps = 1'b1;
            end
            if (m_fade_ticks == 8) begin
                m_fade_ticks = -1;
                m_running = !m_resume_paused;
            end
        end
    end

    function automatic int exp_fade();
        if (m_fade_ticks < 0) return 3;
        if (m_fade_ticks < 4) return 3 - m_fade_ticks;
        return m_fade_ticks - 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("timer", int'(timer), m_timer);
        chk("part", int'(part), (m_timer / 256) % 8);
        chk("frame", int'(frame), (m_timer / 2) % 128);
        chk("fade_level", int'(fade_level), exp_fade());
        chk("cmd_ready", int'(cmd_ready), (m_fade_ticks < 0) ? 1 : 0);
        chk("part_start", int'(part_start), int'(m_ps));
        chk("beat", int'(beat), int'(m_beat));
        chk("paused", int'(paused), (m_fade_ticks >= 0) ? int'(m_resume_paused) : int'(!m_running));
        ps_cnt += int'(part_start);
        beat_cnt += int'(beat);
    endtask

    task automatic step(input bit t, input bit v, input int op, input int p);
        frame_tick = t;
        cmd_valid = v;
        cmd_op = op[1:0];
        cmd_part = p[2:0];
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        int ps0;
        int b0;
        int fade_exp[8];
        fade_exp = '{2, 1, 0, 0, 1, 2, 3, 3};

        do_reset();
        chk("rst_timer", int'(timer), 0);
        chk("rst_fade", int'(fade_level), 3);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_paused", int'(paused), 0);

        ps0 = ps_cnt;
        b0 = beat_cnt;
        ticks(256);
        chk("run_timer", int'(timer), 256);
        chk("run_part", int'(part), 1);
        chk("run_frame", int'(frame), 0);
        chk("run_part_starts", ps_cnt - ps0, 1);
        chk("run_beats", beat_cnt - b0, 8);

        do_reset();
        ticks(40);
        step(1'b0, 1'b1, 1, 0);
        chk("pause_paused", int'(paused), 1);
        ticks(10);
        chk("pause_hold", int'(timer), 40);
        step(1'b0, 1'b1, 0, 0);
        chk("resume_paused", int'(paused), 0);
        ticks(5);
        chk("resume_timer", int'(timer), 45);

        ticks(467);
        chk("jump_from_part", int'(part), 2);
        step(1'b0, 1'b1, 3, 5);
        chk("jump_ready_low", int'(cmd_ready), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 0, 0);
            chk("jump_fade", int'(fade_level), fade_exp[i]);
            chk("jump_ready", int'(cmd_ready), (i == 7) ? 1 : 0);
            if (i == 3) begin
                chk("jump_part", int'(part), 5);
                chk("jump_frame", int'(frame), 0);
                chk("jump_part_start", int'(part_start), 1);
            end
            step(1'b0, 1'b0, 0, 0);
        end
        step(1'b1, 1'b0, 0, 0);
        chk("jump_resume_timer", int'(timer), 1281);

        step(1'b0, 1'b1, 3, 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1, 0);
        step(1'b0, 1'b1, 1, 0);
        chk("held_cmd_paused", int'(paused), 1);
        step(1'b1, 1'b0, 0, 0);
        chk("held_cmd_timer", int'(timer), 256);

        step(1'b1, 1'b1, 0, 0);
        chk("pause_play_same_edge", int'(timer), 256);
        step(1'b1, 1'b1, 1, 0);
        chk("play_pause_same_edge", int'(timer), 257);
        step(1'b1, 1'b0, 0, 0);
        chk("play_pause_hold", int'(timer), 257);

        step(1'b0, 1'b1, 0, 0);
        ticks(3583);
        chk("step_from_part", int'(part), 7);
        step(1'b0, 1'b1, 1, 0);
        step(1'b0, 1'b1, 2, 0);
        ticks(8);
        chk("step_wrap_timer", int'(timer), 2048);
        chk("step_wrap_part", int'(part), 0);
        chk("step_wrap_paused", int'(paused), 1);
        chk("step_wrap_ready", int'(cmd_ready), 1);
        step(1'b1, 1'b0, 0, 0);
        chk("step_wrap_hold", int'(timer), 2048);

        step(1'b0, 1'b1, 3, 4);
        ticks(2);
        do_reset();
        chk("midfade_rst_timer", int'(timer), 0);
        chk("midfade_rst_fade", int'(fade_level), 3);
        chk("midfade_rst_ready", int'(cmd_ready), 1);
        chk("midfade_rst_paused", int'(paused), 0);
        ticks(8);
        chk("midfade_rst_no_target", int'(timer), 8);

        ticks(8183);
        chk("wrap_pre", int'(timer), 8191);
        step(1'b1, 1'b0, 0, 0);
        chk("wrap_timer", int'(timer), 0);
        chk("wrap_part", int'(part), 0);
        chk("wrap_part_start", int'(part_start), 1);
        chk("wrap_beat", int'(beat), 1);

        begin
            bit v;
            int op;
            int p;
            v = 1'b0;
            op = 0;
            p = 0;
            for (int i = 0; i < 3000; i++) begin
                bit ready_now;
                if (!v && $urandom_range(0, 7) == 0) begin
                    v = 1'b1;
                    op = int'($urandom_range(0, 3));
                    p = int'($urandom_range(0, 7));
                end
                reset = ($urandom_range(0, 599) == 0);
                ready_now = (m_fade_ticks < 0);
                step($urandom_range(0, 2) == 0, v, op, p);
                if (ready_now || reset) v = 1'b0;
            end
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demo_sequencer.md
# demo_sequencer

Timeline controller for the VGA demo. Owns the 13-bit demo timer (frame counter plus a one-bit fraction) and derives the part index, the frame-within-part and the beat pulses that drive the effect and audio datapaths. Accepts play, pause, step and jump commands over a valid/ready handshake. Commanded part changes run through a 4-level fade-out/fade-in sequence that the pixel path uses to dim RGB.

## Interface
Parameters:
- `FADE_STEPS`, default 4: number of fade levels; `fade_level` counts 0..FADE_STEPS-1.
- `PART_BITS`, default 3: width of the part index (8 parts).
- `PART_FRAME_BITS`, default 7: frames per part as a power of two (128).

Ports:
- `clk`  in  1: pixel clock, 25.175 MHz.
- `reset`  in  1: synchronous, active-high.
- `frame_tick`  in  1: one-cycle pulse at hpos==0 && vpos==0.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when high on the same edge as `cmd_valid`.
- `cmd_op`  in  2: command opcode.
  - 0 = PLAY
  - 1 = PAUSE
  - 2 = STEP (next part)
  - 3 = JUMP
- `cmd_part`  in  3: target part; used by JUMP only.
- `timer`  out  13: `{frame_counter[11:0], frac}`.
- `part`  out  3: `frame_counter[9:7]`.
- `frame`  out  7: `frame_counter[6:0]`.
- `fade_level`  out  2: 3 = full brightness, 0 = black.
- `part_start`  out  1: one-cycle pulse when `part` changes or is reloaded.
- `beat`  out  1: one-cycle pulse when `timer[4:0]` becomes 0.
- `paused`  out  1: high in PAUSE, and in a fade whose resume mode is PAUSE.

## Operation
States: PLAY, PAUSE, FADE_OUT, FADE_IN. Reset state is PLAY.

Reset values:
- `timer` 0, `part` 0, `frame` 0.
- `fade_level` 3, `cmd_ready` 1.
- `part_start` 0, `beat` 0, `paused` 0.
- Internal `resume_mode` is PLAY.

PLAY:
- Each `frame_tick` does `{frame_counter, frac} += 1`.
- The counter wraps 8191→0 modulo 2^13.

PAUSE:
- `frame_tick` is ignored; all counters hold.

Commands are accepted only in PLAY or PAUSE (`cmd_ready` = 1 there, 0 in both fade states):
- PLAY: go to PLAY.
- PAUSE: go to PAUSE.
- STEP: `target = part + 1` mod 8, then behave as JUMP.
- JUMP:
  - Store `resume_mode` = current state (PLAY or PAUSE).
  - Latch `target`.
  - Go to FADE_OUT.
  - A JUMP to the current part is still a full fade and restart.

FADE_OUT:
- Counters are frozen.
- Each `frame_tick` decrements `fade_level`.
- On the tick that finds `fade_level` == 0:
  - Load `frame_counter[9:7]` = target, `frame_counter[6:0]` = 0, `frac` = 0.
  - `frame_counter[11:10]` is unchanged.
  - Pulse `part_start`.
  - Go to FADE_IN; `fade_level` stays 0.

FADE_IN:
- Counters are frozen.
- Each `frame_tick` increments `fade_level`.
- On the tick that finds `fade_level` == 3: go to `resume_mode`.

Natural part change:
- An increment that changes `frame_counter[9:7]` (including the 4095→0 wrap of `frame_counter`) pulses `part_start`.
- No fade is applied.

`beat`: pulses on any increment whose result has `timer[4:0]` == 0, i.e. every 32 ticks. A jump load does not pulse `beat`.

## Timing
- All outputs are registered. A `frame_tick` at edge t is reflected in `timer`, `part`, `frame`, `fade_level`, `part_start` and `beat` after edge t.
- Pulses last exactly one cycle.
- A command accepted at edge t changes state after t.
- A `frame_tick` coincident with an accepted command is processed under the pre-command state:
  - PLAY + PAUSE in the same cycle → the counter increments once, then holds.
  - PAUSE + PLAY in the same cycle → no increment.
  - PLAY + JUMP in the same cycle → increment, then FADE_OUT.
- Fade length: JUMP accepted → target loaded on the 4th following `frame_tick` → back to full brightness on the 8th.
- `cmd_valid` may stay high while `cmd_ready` is low; the command is taken on the first cycle `cmd_ready` returns high.
- `reset` mid-fade or mid-pause restores all reset values on the next edge, and drops any pending target.

## Structure
- Package `demo_seq_pkg` holds:
  - the state enum;
  - the `cmd_op` encodings;
  - `FADE_MAX` = 3;
  - `TIMER_W` = 13.
- One sub-module, `demo_timeline_counter`:
  - holds the 13-bit counter with increment enable and part-load port;
  - outputs the `part_start` and `beat` pulses.
- The FSM, handshake and fade logic live in the top.

## Test plan
- **Reset and run:** `reset` 1 cycle, then 256 `frame_tick`s in PLAY → `timer` == 256, `part` == 1, `frame` == 0; `part_start` pulses once, at the tick with `timer` 255→256; 8 `beat` pulses.
- **Pause/resume:** PAUSE at `timer` 40, 10 ticks, then PLAY, then 5 ticks → `timer` == 45; `paused` high only during the hold.
- **Jump with fade:** JUMP `cmd_part` = 5 from part 2 in PLAY:
  - `cmd_ready` drops for 8 ticks;
  - `fade_level` reads 2, 1, 0, 0, 1, 2, 3;
  - at the load tick `part` == 5, `frame` == 0, with a `part_start` pulse;
  - counting resumes afterwards.
- **STEP wrap:** STEP while in part 7 while paused → target 0; `frame_counter[11:10]` preserved; state returns to PAUSE after the fade-in.
- **Simultaneous events:**
  - PAUSE and `frame_tick` on the same edge → exactly one increment;
  - `cmd_valid` held during a fade → accepted on the first ready cycle;
  - `reset` mid-FADE_OUT → all reset values, `cmd_ready` == 1.
- **Full wrap:** preload near 8191, tick across → `timer` == 0, `part` == 0; `part_start` and `beat` pulse together.
